// File: rtl/riscv_xlat_fetch_queue.sv
// rtl/riscv_xlat_fetch_queue.sv - group-aware fetch queue between MIPS-to-RISC-V translator and core
module riscv_xlat_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic             in_last,
    input  logic             in_illegal,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic             out_illegal,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] grp_count,
    output logic             grp_open
);
    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      instr_mem [DEPTH];
    logic             last_mem  [DEPTH];
    logic             ill_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] grp_q, grp_d;
    logic             open_q, open_d;

    logic empty;
    logic push;
    logic pop;
    logic grp_inc;
    logic grp_dec;

    assign empty     = (count_q == '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH)) & ~reset;
    // Only complete groups count, so the head can never be an orphaned first half.
    assign out_valid = ~empty & (grp_q != '0) & ~reset;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign grp_inc   = push & in_last;
    assign grp_dec   = pop & last_mem[rd_ptr_q];

    assign out_instr   = (empty | reset) ? NOP  : instr_mem[rd_ptr_q];
    assign out_last    = (empty | reset) ? 1'b0 : last_mem[rd_ptr_q];
    assign out_illegal = (empty | reset) ? 1'b0 : ill_mem[rd_ptr_q];
    assign count       = reset ? '0 : count_q;
    assign grp_count   = reset ? '0 : grp_q;
    assign grp_open    = reset ? 1'b0 : open_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        grp_d    = grp_q;
        open_d   = open_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            grp_d    = '0;
            open_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                open_d   = ~in_last;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            case ({grp_inc, grp_dec})
                2'b10:   grp_d = grp_q + CNT_W'(1);
                2'b01:   grp_d = grp_q - CNT_W'(1);
                default: grp_d = grp_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            grp_q    <= '0;
            open_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            grp_q    <= grp_d;
            open_q   <= open_d;
        end
    end

    // Entry contents are deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push & ~flush) begin
            instr_mem[wr_ptr_q] <= in_instr;
            last_mem[wr_ptr_q]  <= in_last;
            ill_mem[wr_ptr_q]   <= in_illegal;
        end
    end
endmodule

// File: tb/tb_riscv_xlat_fetch_queue.sv
// tb/tb_riscv_xlat_fetch_queue.sv - self-checking bench for riscv_xlat_fetch_queue
module tb_riscv_xlat_fetch_queue;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_last, in_illegal, out_ready;
    logic [31:0]      in_instr;
    logic             in_ready, out_valid, out_last, out_illegal, grp_open;
    logic [31:0]      out_instr;
    logic [CNT_W-1:0] count, grp_count;

    riscv_xlat_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_last(in_last), .in_illegal(in_illegal),
        .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
        .out_last(out_last), .out_illegal(out_illegal), .out_ready(out_ready),
        .count(count), .grp_count(grp_count), .grp_open(grp_open)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: an ordered list of stored words plus the open-group flag.
    logic [31:0] q_instr[$];
    logic        q_last[$];
    logic        q_ill[$];
    logic        m_open = 1'b0;
    logic        m_push, m_pop, m_rst, m_fl, m_ready, m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_groups();
        int g = 0;
        foreach (q_last[i]) if (q_last[i]) g++;
        return g;
    endfunction

    task automatic apply(input logic v, input logic [31:0] ins, input logic l, input logic ill,
                         input logic ordy, input logic fl, input logic rst);
        int n;
        int g;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_last = l; in_illegal = ill;
        out_ready = ordy; flush = fl; reset = rst;
        #1;
        n = q_instr.size();
        g = m_groups();
        m_rst   = rst;
        m_fl    = fl;
        m_ready = (n != DEPTH) && !rst;
        m_ov    = (n != 0) && (g != 0) && !rst;
        m_push  = v && m_ready;
        m_pop   = m_ov && ordy;
        chk("m_in_ready", 32'(in_ready), 32'(m_ready));
        chk("m_out_valid", 32'(out_valid), 32'(m_ov));
        chk("m_out_instr", out_instr, (n == 0 || rst) ? NOP : q_instr[0]);
        chk("m_out_last", 32'(out_last), (n == 0 || rst) ? 32'd0 : 32'(q_last[0]));
        chk("m_out_illegal", 32'(out_illegal), (n == 0 || rst) ? 32'd0 : 32'(q_ill[0]));
        chk("m_count", 32'(count), rst ? 32'd0 : 32'(n));
        chk("m_grp_count", 32'(grp_count), rst ? 32'd0 : 32'(g));
        chk("m_grp_open", 32'(grp_open), rst ? 32'd0 : 32'(m_open));
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_rst || m_fl) begin
            q_instr.delete(); q_last.delete(); q_ill.delete();
            m_open = 1'b0;
        end else begin
            if (m_pop) begin
                void'(q_instr.pop_front()); void'(q_last.pop_front()); void'(q_ill.pop_front());
            end
            if (m_push) begin
                q_instr.push_back(in_instr); q_last.push_back(in_last); q_ill.push_back(in_illegal);
                m_open = !in_last;
            end
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        l;
        logic        ill;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_instr;
        logic        e_last;
        logic        e_ill;
        int          e_cnt;
        int          e_grp;
        logic        e_open;
    } vec_t;

    vec_t vt[22];

    initial begin
        int pushed, popped, seq_cnt;
        logic lst, v;

        // Single-word group, split group, simultaneous push/pop, flush mid-group.
        vt[0]  = '{1, 32'h002081B3, 1, 0, 1, 0, 0, NOP,          0, 0, 0, 0, 0};
        vt[1]  = '{0, 32'h0,        0, 0, 1, 0, 1, 32'h002081B3, 1, 0, 1, 1, 0};
        vt[2]  = '{0, 32'h0,        0, 0, 1, 0, 0, NOP,          0, 0, 0, 0, 0};
        vt[3]  = '{1, 32'h123450B7, 0, 0, 1, 0, 0, NOP,          0, 0, 0, 0, 0};
        vt[4]  = '{0, 32'h0,        0, 0, 1, 0, 0, 32'h123450B7, 0, 0, 1, 0, 1};
        vt[5]  = '{0, 32'h0,        0, 0, 1, 0, 0, 32'h123450B7, 0, 0, 1, 0, 1};
        vt[6]  = '{0, 32'h0,        0, 0, 1, 0, 0, 32'h123450B7, 0, 0, 1, 0, 1};
        vt[7]  = '{1, 32'h67808093, 1, 0, 1, 0, 0, 32'h123450B7, 0, 0, 1, 0, 1};
        vt[8]  = '{0, 32'h0,        0, 0, 1, 0, 1, 32'h123450B7, 0, 0, 2, 1, 0};
        vt[9]  = '{0, 32'h0,        0, 0, 1, 0, 1, 32'h67808093, 1, 0, 1, 1, 0};
        vt[10] = '{0, 32'h0,        0, 0, 1, 0, 0, NOP,          0, 0, 0, 0, 0};
        vt[11] = '{1, 32'hA0000001, 1, 0, 0, 0, 0, NOP,          0, 0, 0, 0, 0};
        vt[12] = '{1, 32'hA0000002, 1, 0, 0, 0, 1, 32'hA0000001, 1, 0, 1, 1, 0};
        vt[13] = '{1, 32'hA0000003, 1, 0, 0, 0, 1, 32'hA0000001, 1, 0, 2, 2, 0};
        vt[14] = '{1, 32'hA0000004, 1, 0, 1, 0, 1, 32'hA0000001, 1, 0, 3, 3, 0};
        vt[15] = '{0, 32'h0,        0, 0, 0, 0, 1, 32'hA0000002, 1, 0, 3, 3, 0};
        vt[16] = '{1, 32'hB0000001, 0, 0, 0, 0, 1, 32'hA0000002, 1, 0, 3, 3, 0};
        vt[17] = '{1, 32'hB0000002, 1, 0, 1, 1, 1, 32'hA0000002, 1, 0, 4, 3, 1};
        vt[18] = '{0, 32'h0,        0, 0, 0, 0, 0, NOP,          0, 0, 0, 0, 0};
        vt[19] = '{1, 32'hC0000001, 1, 1, 1, 0, 0, NOP,          0, 0, 0, 0, 0};
        vt[20] = '{0, 32'h0,        0, 0, 1, 0, 1, 32'hC0000001, 1, 1, 1, 1, 0};
        vt[21] = '{0, 32'h0,        0, 0, 1, 0, 0, NOP,          0, 0, 0, 0, 0};

        // Reset state.
        apply(1, 32'hDEADBEEF, 1, 0, 1, 0, 1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_instr", out_instr, NOP);
        advance();
        apply(0, 32'h0, 0, 0, 0, 0, 1);
        advance();

        for (int i = 0; i < 22; i++) begin
            apply(vt[i].v, vt[i].ins, vt[i].l, vt[i].ill, vt[i].ordy, vt[i].fl, 1'b0);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_out_instr", i), out_instr, vt[i].e_instr);
            chk($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(vt[i].e_last));
            chk($sformatf("vec%0d_out_illegal", i), 32'(out_illegal), 32'(vt[i].e_ill));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_grp_count", i), 32'(grp_count), 32'(vt[i].e_grp));
            chk($sformatf("vec%0d_grp_open", i), 32'(grp_open), 32'(vt[i].e_open));
            advance();
        end

        // Fill to full, then stream 20 more words through the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 32'hF000_0000 + 32'(i), 1, 0, 0, 0, 0);
            advance();
        end
        apply(1, 32'hF000_0000 + 32'(DEPTH), 1, 0, 0, 0, 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'(DEPTH));
        advance();
        pushed = DEPTH;
        popped = 0;
        for (int c = 0; c < 200 && popped < DEPTH + 20; c++) begin
            v = (pushed < DEPTH + 20);
            apply(v, 32'hF000_0000 + 32'(pushed), 1, 0, 1, 0, 0);
            if (m_ov) begin
                chk("wrap_order", out_instr, 32'hF000_0000 + 32'(popped));
                popped++;
            end
            if (m_push) pushed++;
            advance();
        end
        chk("wrap_drained", 32'(popped), 32'(DEPTH + 20));

        // Reset with stored words; stale entries must not reappear.
        for (int i = 0; i < 5; i++) begin
            apply(1, 32'hE000_0000 + 32'(i), 1, 0, 0, 0, 0);
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1, 32'h1111_1111, 1, 0, 1, 0, 1);
            chk("inrst_out_valid", 32'(out_valid), 32'd0);
            chk("inrst_in_ready", 32'(in_ready), 32'd0);
            advance();
        end
        apply(0, 32'h0, 0, 0, 0, 0, 0);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_count", 32'(count), 32'd0);
        chk("postrst_out_instr", out_instr, NOP);
        advance();
        apply(1, 32'hD000_0001, 1, 0, 0, 0, 0);
        advance();
        apply(0, 32'h0, 0, 0, 1, 0, 0);
        chk("postrst_fresh_instr", out_instr, 32'hD000_0001);
        chk("postrst_fresh_count", 32'(count), 32'd1);
        advance();

        // Random traffic against the model; groups of 1 or 2 words.
        seq_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            lst = m_open ? 1'b1 : 1'($urandom_range(0, 1));
            apply(1'($urandom_range(0, 3) != 0), 32'($urandom), lst, 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0),
                  1'($urandom_range(0, 150) == 0));
            if (m_push) seq_cnt++;
            advance();
        end
        chk("rand_progress", 32'(seq_cnt > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_xlat_fetch_queue.md
Name: riscv_xlat_fetch_queue

Overview:
- Sits directly downstream of the MIPS-to-RISC-V translator and buffers the RISC-V words it emits for the core's fetch interface.
- A translator produces a group of 1 or 2 words per MIPS instruction, for example LUI followed by the ADDI/LW second part. The queue releases a group to the core only once every word of that group is stored.
- The core therefore never sees the first word of a split sequence without its partner.
- A flush drops all buffered and partially received groups on redirect.

Parameters:
- DEPTH, 8, number of 32-bit entries. Must be a power of two and at least 4.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counters. Derived; do not override.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all contents.
- in_valid  input  1  translator presents a word.
- in_instr  input  32  translated RISC-V word.
- in_last  input  1  word is the final word of its group.
- in_illegal  input  1  translator flagged the source instruction untranslatable.
- in_ready  output  1  queue accepts a word this cycle.
- out_valid  output  1  head word available to the core.
- out_instr  output  32  head word.
- out_last  output  1  head word ends its group.
- out_illegal  output  1  head word carries the illegal flag.
- out_ready  input  1  core consumes the head word.
- count  output  CNT_W  stored words.
- grp_count  output  CNT_W  complete groups stored.
- grp_open  output  1  the tail group is still missing its last word.

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage:
  - Circular buffer of DEPTH entries, each {instr[31:0], last, illegal}.
  - Write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits; both wrap from DEPTH-1 to 0.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH) & ~reset, combinational.
  - There is no pass-through when full: a pop in the same cycle does not enable a push.
- Output gating:
  - out_valid = (count != 0) & (grp_count != 0), combinational.
  - out_instr, out_last and out_illegal are a combinational read of entry[rd_ptr].
  - When count == 0, outputs are forced to out_instr = 32'h00000013 (NOP), out_last = 0, out_illegal = 0.
- Counters:
  - count += push - pop.
  - grp_count increments on push with in_last = 1 and decrements on pop with head last = 1.
  - Simultaneous increment and decrement leaves grp_count unchanged.
- grp_open:
  - Set on push with in_last = 0.
  - Cleared on push with in_last = 1.
  - Never changed by pop.
- Latency: a word pushed in cycle N that completes a group is presented with out_valid = 1 in cycle N+1 at the earliest.
- Group delivery rule:
  - Once out_valid is asserted for the first word of a group, every remaining word of that group is already stored.
  - Consequently out_valid stays 1 through the group unless flush or reset occurs.
- Full with an open group: in_ready is 0, so the translator stalls.
  - This cannot deadlock: grp_count > 0 always holds in that case, because a group is at most 2 words and DEPTH >= 4.
- Flush:
  - Highest priority below reset.
  - Clears wr_ptr, rd_ptr, count, grp_count and grp_open in the next cycle.
  - A push or pop in the same cycle is discarded and has no effect.
  - in_ready remains asserted during flush.
- Reset:
  - Same state clearing as flush.
  - Output values while and after reset: out_valid = 0, out_instr = 32'h00000013, out_last = 0, out_illegal = 0, count = 0, grp_count = 0, grp_open = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Entry contents are not reset.
- Reset or flush mid-group discards the partial group. A later word with in_last = 1 then forms a one-word group on its own; the translator is responsible for restarting at a group boundary.
- The illegal flag is carried through untouched; the queue takes no action on it.

Test Plan:
1. Single-word group: push 32'h002081B3 with last = 1 while out_ready = 1.
   - Cycle N+1: out_valid = 1, out_instr = 32'h002081B3.
   - After pop: count = 0 and out_instr = 32'h00000013.
2. Split group held back: push LUI 32'h123450B7 with last = 0, idle 3 cycles, then push 32'h67808093 with last = 1.
   - out_valid stays 0 until the cycle after the second push.
   - The two words are then delivered back-to-back with out_last = 0 then 1.
3. Full and wrap: with out_ready = 0, push 8 single-word groups.
   - in_ready = 0 at count = 8.
   - Then set out_ready = 1 and keep pushing for 20 more words: order is preserved across pointer wrap, and there is no push on the cycle the queue pops from full.
4. Simultaneous push/pop: at count = 3 and grp_count = 3, push a last = 1 word and pop a last = 1 head in the same cycle.
   - count stays 3, grp_count stays 3.
5. Flush mid-group: push a last = 0 word, then assert flush together with in_valid.
   - Next cycle: count = 0, grp_count = 0, grp_open = 0, and the flushed-cycle word is absent.
   - A following last = 1 word is delivered alone.
6. Reset during traffic: assert reset with 5 stored words.
   - During reset: out_valid = 0 and in_ready = 0.
   - The cycle after release: in_ready = 1, count = 0, and stale entries are never presented.
